// File: rtl/reg_file_bypass_sb_if.sv
// Decode/write-back bundle for reg_file_bypass_sb: read ports, immediate, commit, load issue.
// The pipeline side uses master; the register file uses slave.
interface reg_file_bypass_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              use_rs;
    logic              use_rt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [15:0]       imm16;
    logic              imm_unsigned;
    logic [DATA_W-1:0] imm_ext;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        load_mode;
    logic [1:0]        byte_off;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic              rs_busy;
    logic              rt_busy;
    logic              stall;
    logic              wb_fault;

    modport master (
        output rs_addr, rt_addr, use_rs, use_rt, imm16, imm_unsigned,
               we, wr_addr, wr_data, load_mode, byte_off, issue_valid, issue_addr,
        input  rs_data, rt_data, imm_ext, rs_busy, rt_busy, stall, wb_fault
    );

    modport slave (
        input  rs_addr, rt_addr, use_rs, use_rt, imm16, imm_unsigned,
               we, wr_addr, wr_data, load_mode, byte_off, issue_valid, issue_addr,
        output rs_data, rt_data, imm_ext, rs_busy, rt_busy, stall, wb_fault
    );
endinterface

// File: rtl/reg_file_bypass_sb.sv
// ID-stage register file: load extraction on write-back, write-through bypass on both
// read ports, pending-load scoreboard driving the decode stall, immediate extension.
module reg_file_bypass_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    reg_file_bypass_sb_if.slave bus
);
    localparam logic [2:0] ModeWord  = 3'd0;
    localparam logic [2:0] ModeHalfU = 3'd1;
    localparam logic [2:0] ModeHalfS = 3'd2;
    localparam logic [2:0] ModeByteU = 3'd3;
    localparam logic [2:0] ModeByteS = 3'd4;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  pending_q, pending_d;
    logic              wb_fault_q, wb_fault_d;

    logic [31:0]       word32;
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;
    logic [DATA_W-1:0] ext_val;
    logic              legal, misaligned, commit;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NREGS;
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Big-endian lane select on the low word
    always_comb begin
        word32   = bus.wr_data[31:0];
        half_sel = bus.byte_off[1] ? word32[15:0] : word32[31:16];
        unique case (bus.byte_off)
            2'd0:    byte_sel = word32[31:24];
            2'd1:    byte_sel = word32[23:16];
            2'd2:    byte_sel = word32[15:8];
            default: byte_sel = word32[7:0];
        endcase

        ext_val = bus.wr_data;
        legal   = 1'b1;
        case (bus.load_mode)
            ModeWord:  ext_val = bus.wr_data;
            ModeHalfU: ext_val = {{(DATA_W-16){1'b0}}, half_sel};
            ModeHalfS: ext_val = {{(DATA_W-16){half_sel[15]}}, half_sel};
            ModeByteU: ext_val = {{(DATA_W-8){1'b0}}, byte_sel};
            ModeByteS: ext_val = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            default:   legal   = 1'b0;
        endcase

        misaligned = ((bus.load_mode == ModeHalfU) || (bus.load_mode == ModeHalfS))
                     && bus.byte_off[0];
        commit     = rst_n && bus.we && legal && !misaligned
                     && in_range(bus.wr_addr) && !is_zero(bus.wr_addr);
        wb_fault_d = bus.we && (!legal || misaligned);
    end

    // Read ports with write-through bypass; busy drops when the commit is bypassed
    always_comb begin
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.rs_busy = 1'b0;
        bus.rt_busy = 1'b0;
        if (in_range(bus.rs_addr) && !is_zero(bus.rs_addr)) begin
            bus.rs_data = (commit && bus.wr_addr == bus.rs_addr) ? ext_val : regs_q[bus.rs_addr];
            bus.rs_busy = pending_q[bus.rs_addr] && !(commit && bus.wr_addr == bus.rs_addr);
        end
        if (in_range(bus.rt_addr) && !is_zero(bus.rt_addr)) begin
            bus.rt_data = (commit && bus.wr_addr == bus.rt_addr) ? ext_val : regs_q[bus.rt_addr];
            bus.rt_busy = pending_q[bus.rt_addr] && !(commit && bus.wr_addr == bus.rt_addr);
        end
        bus.stall = (bus.rs_busy && bus.use_rs) || (bus.rt_busy && bus.use_rt);
    end

    // A newly issued load outranks a same-cycle commit to the same register
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (commit && bus.wr_addr == ADDR_W'(i)) begin
                regs_d[i]    = ext_val;
                pending_d[i] = 1'b0;
            end
            if (rst_n && bus.issue_valid && !is_zero(bus.issue_addr)
                && bus.issue_addr == ADDR_W'(i)) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            pending_q  <= '0;
            wb_fault_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            pending_q  <= pending_d;
            wb_fault_q <= wb_fault_d;
        end
    end

    assign bus.wb_fault = wb_fault_q;
    assign bus.imm_ext  = {{(DATA_W-16){bus.imm16[15] & ~bus.imm_unsigned}}, bus.imm16};

endmodule

// File: tb/tb_reg_file_bypass_sb.sv
// Directed vector bench for reg_file_bypass_sb: one row per clock cycle, outputs checked
// just before the rising edge that commits that row.
module tb_reg_file_bypass_sb;
    logic clk;
    logic rst_n;

    reg_file_bypass_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file_bypass_sb #(
        .DATA_W  (32),
        .NREGS   (32),
        .ADDR_W  (5),
        .ZERO_REG(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic        rst_n;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic        use_rs;
        logic        use_rt;
        logic [15:0] imm16;
        logic        imm_unsigned;
        logic        we;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [2:0]  mode;
        logic [1:0]  off;
        logic        issue_valid;
        logic [4:0]  issue_addr;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_imm;
        logic        e_rs_busy;
        logic        e_rt_busy;
        logic        e_stall;
        logic        e_fault;
    } vec_t;

    vec_t tbl[$];
    int   applied;
    int   miscompares;

    function automatic vec_t idle();
        vec_t v;
        v.chk = 1'b1;  v.rst_n = 1'b1;
        v.rs_addr = '0; v.rt_addr = '0; v.use_rs = 1'b0; v.use_rt = 1'b0;
        v.imm16 = '0;  v.imm_unsigned = 1'b0;
        v.we = 1'b0;   v.wr_addr = '0; v.wr_data = '0; v.mode = '0; v.off = '0;
        v.issue_valid = 1'b0; v.issue_addr = '0;
        v.e_rs = '0;   v.e_rt = '0; v.e_imm = '0;
        v.e_rs_busy = 1'b0; v.e_rt_busy = 1'b0; v.e_stall = 1'b0; v.e_fault = 1'b0;
        return v;
    endfunction

    task automatic cmp(input int idx, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL vec %0d %s: got %h, expected %h", idx, name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        rst_n            = v.rst_n;
        bus.rs_addr      = v.rs_addr;
        bus.rt_addr      = v.rt_addr;
        bus.use_rs       = v.use_rs;
        bus.use_rt       = v.use_rt;
        bus.imm16        = v.imm16;
        bus.imm_unsigned = v.imm_unsigned;
        bus.we           = v.we;
        bus.wr_addr      = v.wr_addr;
        bus.wr_data      = v.wr_data;
        bus.load_mode    = v.mode;
        bus.byte_off     = v.off;
        bus.issue_valid  = v.issue_valid;
        bus.issue_addr   = v.issue_addr;
        #4;
        if (v.chk) begin
            applied++;
            cmp(idx, "rs_data",  bus.rs_data,         v.e_rs);
            cmp(idx, "rt_data",  bus.rt_data,         v.e_rt);
            cmp(idx, "imm_ext",  bus.imm_ext,         v.e_imm);
            cmp(idx, "rs_busy",  32'(bus.rs_busy),   32'(v.e_rs_busy));
            cmp(idx, "rt_busy",  32'(bus.rt_busy),   32'(v.e_rt_busy));
            cmp(idx, "stall",    32'(bus.stall),     32'(v.e_stall));
            cmp(idx, "wb_fault", 32'(bus.wb_fault),  32'(v.e_fault));
        end
    endtask

    initial begin
        vec_t v;
        applied     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.we      = 1'b0;
        bus.issue_valid = 1'b0;

        // Reset twice; the second reset cycle carries a write and an issue that must be ignored
        v = idle(); v.chk = 1'b0; v.rst_n = 1'b0; tbl.push_back(v);
        v = idle(); v.chk = 1'b0; v.rst_n = 1'b0; v.we = 1'b1; v.wr_addr = 7; v.wr_data = 32'h5;
        v.issue_valid = 1'b1; v.issue_addr = 7; tbl.push_back(v);
        v = idle(); v.rs_addr = 7; v.use_rs = 1'b1; v.rt_addr = 3;
        v.imm16 = 16'h8000; v.e_imm = 32'hFFFF8000; tbl.push_back(v);
        // Byte signed, off 1, bypassed on both ports
        v = idle(); v.we = 1'b1; v.wr_addr = 3; v.wr_data = 32'h12F45678; v.mode = 3'b100;
        v.off = 2'd1; v.rs_addr = 3; v.rt_addr = 3; v.e_rs = 32'hFFFFFFF4; v.e_rt = 32'hFFFFFFF4;
        v.imm16 = 16'h8000; v.imm_unsigned = 1'b1; v.e_imm = 32'h00008000; tbl.push_back(v);
        v = idle(); v.rs_addr = 3; v.e_rs = 32'hFFFFFFF4; v.we = 1'b1; v.wr_addr = 4;
        v.wr_data = 32'h8001ABCD; v.mode = 3'b001; v.off = 2'd0; v.rt_addr = 4;
        v.e_rt = 32'h00008001; v.imm16 = 16'h7FFF; v.e_imm = 32'h00007FFF; tbl.push_back(v);
        v = idle(); v.we = 1'b1; v.wr_addr = 5; v.wr_data = 32'h8001ABCD; v.mode = 3'b010;
        v.off = 2'd2; v.rs_addr = 5; v.e_rs = 32'hFFFFABCD; v.rt_addr = 4;
        v.e_rt = 32'h00008001; tbl.push_back(v);
        // Misaligned halfword, then illegal mode: register kept, one-cycle fault
        v = idle(); v.we = 1'b1; v.wr_addr = 5; v.wr_data = 32'h11111111; v.mode = 3'b010;
        v.off = 2'd1; v.rs_addr = 5; v.e_rs = 32'hFFFFABCD; tbl.push_back(v);
        v = idle(); v.rs_addr = 5; v.e_rs = 32'hFFFFABCD; v.e_fault = 1'b1; tbl.push_back(v);
        v = idle(); v.rs_addr = 5; v.e_rs = 32'hFFFFABCD; tbl.push_back(v);
        v = idle(); v.we = 1'b1; v.wr_addr = 5; v.wr_data = 32'h0; v.mode = 3'b110;
        v.rs_addr = 5; v.e_rs = 32'hFFFFABCD; tbl.push_back(v);
        v = idle(); v.rs_addr = 5; v.e_rs = 32'hFFFFABCD; v.e_fault = 1'b1; tbl.push_back(v);
        // Scoreboard on register 9
        v = idle(); v.issue_valid = 1'b1; v.issue_addr = 9; v.rs_addr = 9; v.use_rs = 1'b1;
        tbl.push_back(v);
        v = idle(); v.rs_addr = 9; v.rt_addr = 9; v.use_rs = 1'b1; v.use_rt = 1'b1;
        v.e_rs_busy = 1'b1; v.e_rt_busy = 1'b1; v.e_stall = 1'b1; tbl.push_back(v);
        v = idle(); v.we = 1'b1; v.wr_addr = 9; v.wr_data = 32'hCAFEBABE; v.rs_addr = 9;
        v.use_rs = 1'b1; v.e_rs = 32'hCAFEBABE; tbl.push_back(v);
        v = idle(); v.rs_addr = 9; v.use_rs = 1'b1; v.issue_valid = 1'b1; v.issue_addr = 9;
        v.we = 1'b1; v.wr_addr = 9; v.wr_data = 32'h00000011; v.e_rs = 32'h00000011;
        tbl.push_back(v);
        v = idle(); v.rs_addr = 9; v.use_rs = 1'b1; v.e_rs = 32'h00000011;
        v.e_rs_busy = 1'b1; v.e_stall = 1'b1; tbl.push_back(v);
        // Faulted write leaves the pending bit and the data alone
        v = idle(); v.rs_addr = 9; v.use_rs = 1'b1; v.we = 1'b1; v.wr_addr = 9;
        v.wr_data = 32'h99; v.mode = 3'b001; v.off = 2'd1; v.e_rs = 32'h00000011;
        v.e_rs_busy = 1'b1; v.e_stall = 1'b1; tbl.push_back(v);
        v = idle(); v.rs_addr = 9; v.use_rs = 1'b1; v.we = 1'b1; v.wr_addr = 9;
        v.wr_data = 32'h22; v.e_rs = 32'h22; v.e_fault = 1'b1; tbl.push_back(v);
        // Register 0: write and issue ignored
        v = idle(); v.rs_addr = 0; v.use_rs = 1'b1; v.we = 1'b1; v.wr_addr = 0;
        v.wr_data = 32'hDEADBEEF; v.issue_valid = 1'b1; v.issue_addr = 0; v.rt_addr = 3;
        v.e_rt = 32'hFFFFFFF4; tbl.push_back(v);
        v = idle(); v.rs_addr = 0; v.use_rs = 1'b1; v.rt_addr = 6; v.we = 1'b1; v.wr_addr = 6;
        v.wr_data = 32'h12F45678; v.mode = 3'b011; v.off = 2'd3; v.e_rt = 32'h00000078;
        tbl.push_back(v);
        v = idle(); v.rt_addr = 6; v.e_rt = 32'h00000078; v.rs_addr = 3; v.e_rs = 32'hFFFFFFF4;
        v.we = 1'b1; v.wr_addr = 7; v.wr_data = 32'h80000000; v.mode = 3'b100; v.off = 2'd0;
        tbl.push_back(v);
        v = idle(); v.rs_addr = 7; v.e_rs = 32'hFFFFFF80; v.we = 1'b1; v.wr_addr = 8;
        v.wr_data = 32'h8001ABCD; v.mode = 3'b001; v.off = 2'd2; v.rt_addr = 8;
        v.e_rt = 32'h0000ABCD; tbl.push_back(v);
        // Stall follows the use_* qualifiers
        v = idle(); v.issue_valid = 1'b1; v.issue_addr = 10; v.rs_addr = 8;
        v.e_rs = 32'h0000ABCD; tbl.push_back(v);
        v = idle(); v.rs_addr = 10; v.rt_addr = 10; v.use_rt = 1'b1;
        v.e_rs_busy = 1'b1; v.e_rt_busy = 1'b1; v.e_stall = 1'b1; tbl.push_back(v);
        v = idle(); v.rs_addr = 10; v.rt_addr = 10; v.e_rs_busy = 1'b1; v.e_rt_busy = 1'b1;
        tbl.push_back(v);

        foreach (tbl[i]) apply(i, tbl[i]);

        // Mid-run reset clears pending bits and stored data
        v = idle(); v.chk = 1'b0; v.rst_n = 1'b0; apply(100, v);
        v = idle(); v.rs_addr = 10; v.use_rs = 1'b1; v.rt_addr = 3; apply(101, v);
        // Fault pulse is a single cycle even when faults are back-to-back then stop
        v = idle(); v.we = 1'b1; v.wr_addr = 2; v.mode = 3'b111; apply(102, v);
        v = idle(); v.we = 1'b1; v.wr_addr = 2; v.mode = 3'b001; v.off = 2'd3;
        v.e_fault = 1'b1; apply(103, v);
        v = idle(); v.rs_addr = 2; v.e_fault = 1'b1; apply(104, v);
        v = idle(); v.rs_addr = 2; apply(105, v);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
